// File: rtl/expr_ctrl.sv
// expr_ctrl: stream front-end for the single-digit '+'/'*' expression recognizer (expr).
// Collects one expression from a valid/ready byte stream that may contain gaps. Clears the
// recognizer, then replays the expression on consecutive cycles. Samples the verdict and
// returns it over a valid/ready result handshake.
//
// Ports:
//   clk, clr               clock; synchronous active-low reset
//   in_valid/in_ready      input char handshake; in_data = ASCII char, in_last = end of expr
//   rec_clr, rec_in        clear and char stream driven into the recognizer
//   rec_out                recognizer verdict (Moore, chars captured so far)
//   res_valid/res_ready    result handshake
//   res_ok, res_ovf        accepted / overflowed (res_ok forced 0 on overflow)
//   res_len                chars stored (saturates at DEPTH)
module expr_ctrl #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned LEN_W = 5
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             rec_clr,
   output logic [7:0]       rec_in,
   input  logic             rec_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_ok,
   output logic             res_ovf,
   output logic [LEN_W-1:0] res_len
);

   localparam int unsigned      IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

   typedef enum logic [2:0] {
      StCollect,
      StClear,
      StFeed,
      StSample,
      StReport
   } state_e;

   state_e           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] rp_q, rp_d;
   logic             ovf_q, ovf_d;
   logic             res_ok_q, res_ok_d;
   logic             res_ovf_q, res_ovf_d;
   logic [LEN_W-1:0] res_len_q, res_len_d;

   // All handshake/recognizer outputs are registered so that their reset values are
   // well defined and the recognizer sees a glitch-free, cycle-exact char stream.
   logic             in_ready_q, in_ready_d;
   logic             rec_clr_q, rec_clr_d;
   logic [7:0]       rec_in_q, rec_in_d;
   logic             res_valid_q, res_valid_d;

   logic [7:0]       buf_mem [DEPTH];

   logic             accept;
   logic             has_room;
   logic             buf_we;

   // in_ready_q is only high in COLLECT, so it doubles as the state qualifier.
   assign accept   = in_valid && in_ready_q;
   assign has_room = (len_q < DEPTH_L);
   assign buf_we   = accept && has_room;

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      rp_d      = rp_q;
      ovf_d     = ovf_q;
      res_ok_d  = res_ok_q;
      res_ovf_d = res_ovf_q;
      res_len_d = res_len_q;

      unique case (state_q)
         StCollect: begin
            if (accept) begin
               if (has_room) begin
                  len_d = len_q + LEN_W'(1);
               end else begin
                  ovf_d = 1'b1;
               end
               if (in_last) begin
                  // ovf_d already includes this beat's own overflow effect.
                  if (ovf_d) begin
                     state_d   = StReport;
                     res_ok_d  = 1'b0;
                     res_ovf_d = 1'b1;
                     res_len_d = DEPTH_L;
                  end else begin
                     state_d = StClear;
                  end
               end
            end
         end
         StClear: begin
            rp_d    = '0;
            state_d = StFeed;
         end
         StFeed: begin
            rp_d = rp_q + LEN_W'(1);
            // len is at least 1 here: the closing beat always fits when ovf is clear.
            if (rp_q == len_q - LEN_W'(1)) begin
               state_d = StSample;
            end
         end
         StSample: begin
            // The last char was captured at the end of the final FEED cycle.
            res_ok_d  = rec_out;
            res_len_d = len_q;
            res_ovf_d = 1'b0;
            state_d   = StReport;
         end
         StReport: begin
            if (res_ready) begin
               len_d   = '0;
               ovf_d   = 1'b0;
               state_d = StCollect;
            end
         end
         default: begin
            state_d = StCollect;
         end
      endcase

      // Registered outputs are decoded from the next state.
      in_ready_d  = (state_d == StCollect);
      rec_clr_d   = (state_d == StClear);
      res_valid_d = (state_d == StReport);
      rec_in_d    = (state_d == StFeed) ? buf_mem[rp_d[IDX_W-1:0]] : 8'h00;
   end

   always_ff @(posedge clk) begin
      if (!clr) begin
         state_q     <= StCollect;
         len_q       <= '0;
         rp_q        <= '0;
         ovf_q       <= 1'b0;
         res_ok_q    <= 1'b0;
         res_ovf_q   <= 1'b0;
         res_len_q   <= '0;
         in_ready_q  <= 1'b0;
         rec_clr_q   <= 1'b1;
         rec_in_q    <= 8'h00;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         rp_q        <= rp_d;
         ovf_q       <= ovf_d;
         res_ok_q    <= res_ok_d;
         res_ovf_q   <= res_ovf_d;
         res_len_q   <= res_len_d;
         in_ready_q  <= in_ready_d;
         rec_clr_q   <= rec_clr_d;
         rec_in_q    <= rec_in_d;
         res_valid_q <= res_valid_d;
      end
   end

   // Buffer storage needs no reset: len_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         buf_mem[len_q[IDX_W-1:0]] <= in_data;
      end
   end

   assign in_ready  = in_ready_q;
   assign rec_clr   = rec_clr_q;
   assign rec_in    = rec_in_q;
   assign res_valid = res_valid_q;
   assign res_ok    = res_ok_q;
   assign res_ovf   = res_ovf_q;
   assign res_len   = res_len_q;

endmodule

// File: doc/expr_ctrl.md
# expr_ctrl

Stream controller that sequences the existing `expr` recognizer, the single-digit `+`/`*` expression checker clocked one ASCII char per cycle. The recognizer consumes a character on every clock edge, so it cannot tolerate gaps. `expr_ctrl` therefore buffers one complete expression from a valid/ready byte stream, which may contain gaps. It then clears the recognizer, replays the expression in consecutive cycles, samples the verdict, and returns it over a result handshake.

## Interface
Parameters:
- `DEPTH`, 16: expression buffer entries (max expression length).
- `LEN_W`, 5: width of length fields; must be ≥ log2(DEPTH)+1.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `clr`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: input char valid.
- `in_ready`  out  1: controller can accept a char.
- `in_data`  in  8: ASCII char.
- `in_last`  in  1: this char ends the expression.
- `rec_clr`  out  1: clear to `expr` (active-high).
- `rec_in`  out  8: char driven into `expr`.
- `rec_out`  in  1: `expr` verdict (Moore; reflects chars captured so far).
- `res_valid`  out  1: result available.
- `res_ready`  in  1: result consumer ready.
- `res_ok`  out  1: expression accepted by `expr`.
- `res_ovf`  out  1: expression exceeded `DEPTH`; `res_ok` forced 0.
- `res_len`  out  `LEN_W`: chars stored (saturates at `DEPTH`).

## Operation
- FSM states: COLLECT, CLEAR, FEED, SAMPLE, REPORT.
- **COLLECT**
  - `in_ready`=1; a beat transfers when `in_valid && in_ready`.
  - Each beat is written to `buf[len]` and `len` is incremented, while `len < DEPTH`.
  - Beats arriving when `len == DEPTH` are dropped and set `ovf`.
- **Leaving COLLECT** on an accepted beat with `in_last`=1 (including that beat's own overflow effect):
  - If `ovf`=0, go to CLEAR.
  - If `ovf`=1, go straight to REPORT with `ok`=0 and `len`=`DEPTH`; the recognizer is not run.
- **CLEAR** (1 cycle): `rec_clr`=1, `rec_in`=0, read pointer `rp`=0.
- **FEED** (exactly `len` cycles): `rec_in`=`buf[rp]`, `rp`++ each cycle; `rec_clr`=0. When `rp == len-1`, the next state is SAMPLE.
- **SAMPLE** (1 cycle): `rec_in`=0. At the end of the cycle, register `res_ok`<=`rec_out`, `res_len`<=`len`, `res_ovf`<=0; go to REPORT.
- **REPORT**
  - `res_valid`=1; `res_*` held stable; `in_ready`=0.
  - On `res_valid && res_ready`, clear `len`/`ovf` and go to COLLECT.
- Outside FEED, `rec_in`=0. Outside CLEAR and reset, `rec_clr`=0.
- Only one expression is in flight. The next expression is not accepted until its result is taken.

## Timing
- While `clr`=0, at the next edge:
  - state goes to COLLECT;
  - `len`, `rp` and `ovf` go to 0;
  - `in_ready`, `res_valid`, `res_ok`, `res_ovf` and `res_len` go to 0;
  - `rec_in` goes to 0 and `rec_clr` goes to 1.
- The `rec_clr`=1 reset value keeps `expr` held clear. The first cycle after reset release has `in_ready`=1 and `rec_clr`=0.
- The recognizer captures `rec_in` at the end of each FEED cycle. The verdict on `rec_out` is valid in the SAMPLE cycle, i.e. one cycle after the last char is driven.
- Latency for an accepted `in_last` beat in cycle t with N chars:
  - CLEAR in t+1;
  - FEED in t+2 .. t+1+N;
  - SAMPLE in t+2+N;
  - `res_valid` first high in t+3+N.
- Overflow path: `res_valid` is high in t+1.
- `res_ready` may be high before `res_valid`; the handshake then completes in the first REPORT cycle, and `in_ready` is high the following cycle.
- Exactly `DEPTH` chars is legal and not an overflow. Overflow requires a `DEPTH+1`-th beat.
- Reset asserted in any state aborts the operation: the buffer is discarded and no result is emitted.

## Test plan
- **Contiguous valid expression.** Send 49,43,50,42,51 ("1+2*3") on consecutive cycles, `in_last` on 51, `res_ready`=1.
  - `rec_clr` pulses one cycle, then `rec_in` = 49,43,50,42,51 on consecutive cycles.
  - `res_valid` 8 cycles after the last beat, with `res_ok`=1, `res_ovf`=0, `res_len`=5.
- **Gapped input.** Same chars with `in_valid` low for 3 cycles between each beat.
  - `rec_in` burst is still 5 consecutive cycles; same result.
- **Invalid expression.** Send 49,43 ("1+"), `in_last` on 43.
  - `res_ok`=0, `res_len`=2.
  - Then 51 alone: `res_ok`=1, `res_len`=1, which proves the clear between expressions.
- **Overflow.** Send 17 chars "1+1+...+1" (last 49 with `in_last`).
  - `res_ovf`=1, `res_ok`=0, `res_len`=16.
  - No `rec_clr` pulse; `rec_in` stays 0.
- **Result backpressure.** Hold `res_ready`=0 for 5 cycles in REPORT.
  - `res_valid`/`res_ok`/`res_len` stable and `in_ready`=0 throughout.
  - On `res_ready`=1, one handshake, then `in_ready`=1 next cycle.
- **Reset mid-FEED.** Assert `clr`=0 for 1 cycle during the 3rd FEED cycle of "1+2*3".
  - Next cycle: `rec_in`=0, `rec_clr`=1, `res_valid`=0.
  - After release, a fresh "1" yields `res_ok`=1, `res_len`=1.
